// File: rtl/complex_add_sub.sv
// complex_add_sub: first radix-2 DIT butterfly stage, a 4-point DFT of real samples with packed complex outputs.
// Define CAS_SATURATE_EN to clamp out-of-range output fields; by default they wrap to the low bits.
module complex_add_sub #(
    parameter int IN_W    = 16,
    parameter int FIELD_W = 8,
    localparam int OUT_W  = 2*FIELD_W+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  x0,
    input  logic [IN_W-1:0]  x4,
    input  logic [IN_W-1:0]  x2,
    input  logic [IN_W-1:0]  x6,
    output logic             out_valid,
    output logic [OUT_W-1:0] y0r,
    output logic [OUT_W-1:0] y1r,
    output logic [OUT_W-1:0] y2r,
    output logic [OUT_W-1:0] y3r
);
    localparam int W1 = IN_W + 1;
    localparam int W2 = IN_W + 2;
    localparam logic signed [W2-1:0] F_MAX = W2'(2**(FIELD_W-1) - 1);
    localparam logic signed [W2-1:0] F_MIN = ~F_MAX;

    function automatic logic ovf(input logic signed [W2-1:0] v);
        return v > F_MAX || v < F_MIN;
    endfunction

    function automatic logic [FIELD_W-1:0] narrow(input logic signed [W2-1:0] v);
`ifdef CAS_SATURATE_EN
        return v > F_MAX ? F_MAX[FIELD_W-1:0] : v < F_MIN ? F_MIN[FIELD_W-1:0] : v[FIELD_W-1:0];
`else
        return v[FIELD_W-1:0];
`endif
    endfunction

    // Layout: real field, overflow flag, imag field.
    function automatic logic [OUT_W-1:0] pack(input logic signed [W2-1:0] re, input logic signed [W2-1:0] im);
        return {narrow(re), ovf(re) | ovf(im), narrow(im)};
    endfunction

    logic signed [W1-1:0] w_a, w_b, w_c, w_d;
    logic signed [W1-1:0] r_s0, r_d0, r_s1, r_d1;
    logic                 r_v1;
    logic signed [W2-1:0] w_s0, w_d0, w_s1, w_d1;

    assign w_a = {x0[IN_W-1], x0};
    assign w_b = {x4[IN_W-1], x4};
    assign w_c = {x2[IN_W-1], x2};
    assign w_d = {x6[IN_W-1], x6};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0 <= '0;
            r_d0 <= '0;
            r_s1 <= '0;
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s0 <= w_a + w_b;
                r_d0 <= w_a - w_b;
                r_s1 <= w_c + w_d;
                r_d1 <= w_c - w_d;
            end
        end
    end

    assign w_s0 = {r_s0[W1-1], r_s0};
    assign w_d0 = {r_d0[W1-1], r_d0};
    assign w_s1 = {r_s1[W1-1], r_s1};
    assign w_d1 = {r_d1[W1-1], r_d1};

    // X1 = d0 - j*d1, X3 = d0 + j*d1; X0/X2 are purely real.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y0r       <= '0;
            y1r       <= '0;
            y2r       <= '0;
            y3r       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                y0r <= pack(w_s0 + w_s1, '0);
                y1r <= pack(w_d0, -w_d1);
                y2r <= pack(w_s0 - w_s1, '0);
                y3r <= pack(w_d0, w_d1);
            end
        end
    end
endmodule

// File: tb/tb_complex_add_sub.sv
// tb_complex_add_sub: randomized and directed checks of complex_add_sub against an arithmetic DFT model.
module tb_complex_add_sub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x0 = '0, x4 = '0, x2 = '0, x6 = '0;
    logic        out_valid;
    logic [16:0] y0r, y1r, y2r, y3r;

    complex_add_sub dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .x0(x0), .x4(x4), .x2(x2), .x6(x6),
        .out_valid(out_valid), .y0r(y0r), .y1r(y1r), .y2r(y2r), .y3r(y3r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               due;
        logic [3:0][16:0] y;
    } exp_t;

    exp_t             q[$];
    int               cyc = 0;
    int               n_vec = 0;
    int               n_miss = 0;
    logic             exp_v = 1'b0;
    logic [3:0][16:0] exp_y = '0;
    logic [3:0][16:0] got_y;

    assign got_y = {y3r, y2r, y1r, y0r};

    function automatic logic [7:0] nar(input int v);
        int t;
`ifdef CAS_SATURATE_EN
        t = v > 127 ? 127 : (v < -128 ? -128 : v);
`else
        t = ((v % 256) + 256) % 256;
`endif
        return 8'(t);
    endfunction

    function automatic logic [16:0] pk(input int re, input int im);
        return {nar(re), (re > 127 || re < -128 || im > 127 || im < -128), nar(im)};
    endfunction

    // 4-point DFT of real a,b,c,d with outputs in the stage's X0..X3 order.
    function automatic logic [3:0][16:0] model(input int a, input int b, input int c, input int d);
        logic [3:0][16:0] y;
        y[0] = pk(a + b + c + d, 0);
        y[1] = pk(a - b, d - c);
        y[2] = pk(a + b - c - d, 0);
        y[3] = pk(a - b, c - d);
        return y;
    endfunction

    task automatic step(input bit v, input int a, input int b, input int c, input int d, input bit rst);
        exp_t e;
        rst_n = !rst;
        in_valid = v;
        x0 = 16'(a);
        x4 = 16'(b);
        x2 = 16'(c);
        x6 = 16'(d);
        if (v && !rst) begin
            e.due = cyc + 2;
            e.y = model(a, b, c, d);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            exp_v = 1'b0;
            exp_y = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_v = 1'b1;
            exp_y = q[0].y;
            void'(q.pop_front());
        end else begin
            exp_v = 1'b0;
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        n_vec++;
        if (out_valid !== 1'b0 || got_y !== '0) begin
            n_miss++;
            $display("FAIL reset: got v=%b y=%h, expected v=0 y=0", out_valid, got_y);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_directed();
        step(1, 1, 5, 3, 7, 0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL directed_latency: got out_valid=%b one cycle after input, expected 0", out_valid);
        end
        step(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || y0r !== {8'd16, 1'b0, 8'd0} || y1r !== {8'hFC, 1'b0, 8'h04}
            || y2r !== {8'hFC, 1'b0, 8'h00} || y3r !== {8'hFC, 1'b0, 8'hFC}) begin
            n_miss++;
            $display("FAIL directed_1537: got v=%b y=%h, expected v=1 y0=%h y1=%h y2=%h y3=%h",
                     out_valid, got_y, {8'd16, 1'b0, 8'd0}, {8'hFC, 1'b0, 8'h04},
                     {8'hFC, 1'b0, 8'h00}, {8'hFC, 1'b0, 8'hFC});
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        logic [7:0] pos_re, neg_re;
`ifdef CAS_SATURATE_EN
        pos_re = 8'h7F;
        neg_re = 8'h80;
`else
        pos_re = 8'h90;
        neg_re = 8'h70;
`endif
        step(1, 100, 100, 100, 100, 0);
        step(1, -100, -100, -100, -100, 0);
        n_vec++;
        if (out_valid !== 1'b1 || y0r !== {pos_re, 1'b1, 8'h00} || {y3r, y2r, y1r} !== '0) begin
            n_miss++;
            $display("FAIL overflow_pos: got v=%b y=%h, expected y0=%h others 0", out_valid, got_y, {pos_re, 1'b1, 8'h00});
        end
        step(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || y0r !== {neg_re, 1'b1, 8'h00} || {y3r, y2r, y1r} !== '0) begin
            n_miss++;
            $display("FAIL overflow_neg: got v=%b y=%h, expected y0=%h others 0", out_valid, got_y, {neg_re, 1'b1, 8'h00});
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1, 10 * i + 1, -3 * i, 7 - i, 2 * i + 20, 0);
            else step(0, 0, 0, 0, 0, 0);
            pulses += int'(out_valid);
            n_vec++;
            if (out_valid !== exp_v || got_y !== exp_y) begin
                n_miss++;
                $display("FAIL back_to_back[%0d]: got v=%b y=%h, expected v=%b y=%h", i, out_valid, got_y, exp_v, exp_y);
            end
        end
        n_vec++;
        if (pulses != 4) begin
            n_miss++;
            $display("FAIL back_to_back_pulses: got %0d out_valid pulses, expected 4", pulses);
        end
    endtask

    task automatic test_gap();
        step(1, 1234, -567, 89, -10, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, rnd16(), rnd16(), rnd16(), rnd16(), 0);
            n_vec++;
            if (out_valid !== exp_v || got_y !== exp_y) begin
                n_miss++;
                $display("FAIL gap[%0d]: got v=%b y=%h, expected v=%b y=%h", i, out_valid, got_y, exp_v, exp_y);
            end
        end
    endtask

    task automatic test_reset_midflight();
        step(1, 40, 30, 20, 10, 0);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_valid !== 1'b0 || got_y !== '0) begin
                n_miss++;
                $display("FAIL reset_midflight[%0d]: got v=%b y=%h, expected v=0 y=0", i, out_valid, got_y);
            end
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_random();
        int a, b, c, d;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1) == 0) begin
                a = rnd16(); b = rnd16(); c = rnd16(); d = rnd16();
            end else begin
                a = int'($urandom_range(80)) - 40; b = int'($urandom_range(80)) - 40;
                c = int'($urandom_range(80)) - 40; d = int'($urandom_range(80)) - 40;
            end
            step($urandom_range(9) < 7, a, b, c, d, $urandom_range(49) == 0);
            n_vec++;
            if (out_valid !== exp_v || got_y !== exp_y) begin
                n_miss++;
                $display("FAIL random[%0d]: got v=%b y=%h, expected v=%b y=%h", i, out_valid, got_y, exp_v, exp_y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_back_to_back();
        test_gap();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
